array_div_sequential: RTL

Sequential restoring divider: the inverse of the 4x4 array multiplier. It takes an 8-bit dividend (a multiplier-product-sized value) and a 4-bit divisor, and produces a 4-bit quotient and a 4-bit remainder after a fixed number of clocks. It sits behind the same Tiny Tapeout user-project pinout as the multiplier, so the same cocotb bench style drives it. Division by zero and quotient overflow are flagged, not computed.

---
 rtl/array_div_sequential.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/array_div_sequential.sv
// array_div_sequential: 8-bit by 4-bit sequential restoring divider.
// It produces a 4-bit quotient and a 4-bit remainder on the Tiny Tapeout pinout.
// Division by zero and quotient overflow raise err and return 8'hFF.
// Optional build macro DIV_ROUNDTRIP_CHECK_EN adds a checker.
// The checker recomputes Q*B+R one cycle after DONE and flags any mismatch on chk_fail.
module array_div_sequential #(
  parameter int STEPS = 1  // quotient bits resolved per RUN clock: 1, 2 or 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int ITERS = 4 / STEPS;
  localparam logic [1:0] LAST_CNT = 2'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [3:0] b_q, b_d;
  logic [3:0] dvd_q, dvd_d;      // dividend bits still to be shifted in, MSB first
  logic [3:0] rem_q, rem_d;
  logic [3:0] quo_q, quo_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] uo_q, uo_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       chk_fail_q, chk_fail_d;

  logic [3:0] divisor;
  logic       start_in;
  logic       start_ev;
  logic       bad_op;

  assign divisor  = uio_in[3:0];
  assign start_in = uio_in[4];
  assign start_ev = start_in & ~start_q;
  // An 8/4 divide fits a 4-bit quotient only when the high nibble is below the divisor.
  // This also covers B==0.
  assign bad_op   = (divisor == 4'd0) || (ui_in[7:4] >= divisor);

  logic unused_inputs;
  assign unused_inputs = &{1'b0, uio_in[7:5]};

`ifdef DIV_ROUNDTRIP_CHECK_EN
  logic [7:0] a_q, a_d;
  logic       chk_pend_q, chk_pend_d;
  logic [7:0] pp [4];
  logic [7:0] acc [5];
  logic [7:0] roundtrip;

  // Array-multiplier structure: AND-row partial products of Q and B.
  // The rows are summed onto R through a ripple chain.
  assign acc[0] = {4'h0, uo_q[7:4]};
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mul_row
      assign pp[gi]     = uo_q[gi] ? (8'(b_q) << gi) : 8'h00;
      assign acc[gi+1]  = acc[gi] + pp[gi];
    end
  endgenerate
  assign roundtrip = acc[4];
`endif

  logic [3:0] step_rem, step_quo, step_dvd;
  logic [4:0] trial;

  // STEPS restoring iterations per clock.
  // Each iteration shifts in one dividend bit, then subtracts B when it fits.
  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    step_dvd = dvd_q;
    trial    = 5'd0;
    for (int k = 0; k < STEPS; k++) begin
      trial    = {step_rem, step_dvd[3]};
      step_dvd = {step_dvd[2:0], 1'b0};
      if (trial >= {1'b0, b_q}) begin
        trial    = trial - {1'b0, b_q};
        step_quo = {step_quo[2:0], 1'b1};
      end else begin
        step_quo = {step_quo[2:0], 1'b0};
      end
      step_rem = trial[3:0];
    end
  end

  // Next-state and registered-output logic; everything holds while ena is low.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    b_d        = b_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    uo_d       = uo_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    chk_fail_d = chk_fail_q;
`ifdef DIV_ROUNDTRIP_CHECK_EN
    a_d        = a_q;
    chk_pend_d = chk_pend_q;
`endif
    if (ena) begin
      start_d = start_in;
      case (state_q)
        IDLE, DONE: begin
          if (start_ev) begin
            b_d        = divisor;
            done_d     = 1'b0;
            err_d      = 1'b0;
            chk_fail_d = 1'b0;
`ifdef DIV_ROUNDTRIP_CHECK_EN
            a_d        = ui_in;
            chk_pend_d = 1'b0;
`endif
            if (bad_op) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              quo_d   = 4'hF;
              rem_d   = 4'hF;
              uo_d    = 8'hFF;
              state_d = DONE;
            end else begin
              // The high nibble is already known to be below B.
              // It therefore seeds the partial remainder and skips four zero quotient bits.
              rem_d   = ui_in[7:4];
              dvd_d   = ui_in[3:0];
              quo_d   = 4'h0;
              cnt_d   = 2'd0;
              busy_d  = 1'b1;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          rem_d = step_rem;
          quo_d = step_quo;
          dvd_d = step_dvd;
          if (cnt_q == LAST_CNT) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            uo_d    = {step_rem, step_quo};
            state_d = DONE;
`ifdef DIV_ROUNDTRIP_CHECK_EN
            chk_pend_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef DIV_ROUNDTRIP_CHECK_EN
      // One cycle after a non-error result lands, compare Q*B+R against the latched A.
      if (state_q == DONE && chk_pend_q && !start_ev) begin
        chk_pend_d = 1'b0;
        chk_fail_d = (roundtrip != a_q);
      end
`endif
    end
  end

  // State registers; start_q resets high so a start held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b1;
      b_q        <= 4'h0;
      dvd_q      <= 4'h0;
      rem_q      <= 4'h0;
      quo_q      <= 4'h0;
      cnt_q      <= 2'd0;
      uo_q       <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      chk_fail_q <= 1'b0;
`ifdef DIV_ROUNDTRIP_CHECK_EN
      a_q        <= 8'h00;
      chk_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      b_q        <= b_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      uo_q       <= uo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      chk_fail_q <= chk_fail_d;
`ifdef DIV_ROUNDTRIP_CHECK_EN
      a_q        <= a_d;
      chk_pend_q <= chk_pend_d;
`endif
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {err_q, done_q, busy_q, chk_fail_q, 4'h0};
`ifdef DIV_ROUNDTRIP_CHECK_EN
  assign uio_oe  = 8'hF0;
`else
  assign uio_oe  = 8'hE0;
`endif

endmodule
